pattern_event_monitor: RTL and testbench
========================================

# pattern_event_monitor

Sequential stage directly downstream of the wildcard pattern detector. Each cycle it takes the detector's 8-bit data word and its three match flags, qualified by a valid strobe. It keeps a saturating hit count per pattern and buffers matching words in a small FIFO that drains over a valid/ready handshake. It also raises an alarm when matches occur on several consecutive valid samples.

## Interface
- DEPTH, 4, event FIFO entries; power of two, 2 or more
- CNT_W, 16, width of each per-pattern hit counter
- RUN_THRESH, 3, consecutive matching samples needed to raise the alarm; 1 or more
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data/in_hit qualify this cycle
- in_data  in  8  word seen by the detector
- in_hit  in  3  {has_pattern3, has_pattern2, has_pattern1}
- clear  in  1  synchronous flush of counters, FIFO, FSM and overflow
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head when evt_valid is also high
- evt_data  out  8  head entry data
- evt_hit  out  3  head entry hit flags
- cnt1, cnt2, cnt3  out  CNT_W  hit counts for pattern 1, 2, 3
- run_alarm  out  1  level; high while run FSM is in ALARM
- overflow  out  1  sticky; an event was dropped because the FIFO was full

## Operation
- Reset (rst_n=0, asynchronous): counters=0, FIFO empty, evt_valid=0, evt_data=0, evt_hit=0, run_alarm=0, overflow=0, FSM=IDLE.
- Accepted sample: in_valid=1 and clear=0.
- Counters: for each set bit of in_hit on an accepted sample, the matching cntN increments by 1. A counter saturates at 2^CNT_W-1. Several bits in one sample increment several counters.
- Push: an accepted sample with in_hit != 0 pushes {in_data, in_hit}. Samples with in_hit == 0 are never stored.
- Pop: evt_valid && evt_ready.
- FIFO full with push and no pop: the entry is dropped and overflow is set to 1. overflow stays at 1 until clear or reset.
- FIFO full with push and pop in the same cycle: both occur, no drop, and the FIFO stays full.
- FIFO empty with push: there is no bypass. The entry appears on the head the next cycle.
- Pointers wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit so full and empty are distinguishable.
- Run FSM, with run_len as a counter. All transitions happen only on accepted samples; cycles with in_valid=0 hold state.
  - IDLE: a hit sample sets run_len=1 and goes to RUN. If RUN_THRESH=1 it goes straight to ALARM.
  - RUN: a hit sample increments run_len. When run_len reaches RUN_THRESH it goes to ALARM. A no-hit sample goes to IDLE and sets run_len=0.
  - ALARM: a hit sample stays in ALARM. A no-hit sample goes to IDLE.
- clear=1 for one cycle zeroes the counters, empties the FIFO, sets the FSM to IDLE and clears overflow. A sample presented in the same cycle is ignored, so clear has priority. A pop in the same cycle is also discarded.

## Timing
- All outputs are registered.
- Latency from an accepted sample:
  - counters, run_alarm and overflow update at the next clock edge.
  - a pushed entry on an empty FIFO appears on evt_* one cycle later.
- Head holds stable while evt_valid=1 and evt_ready=0.
- After a pop, the next entry is presented on the following edge, so back-to-back pops run at 1 per cycle.
- Throughput is one sample per cycle, with no input backpressure; overflow signals loss.
- Reset asserted mid-operation clears the block immediately. No stored event survives.

## Structure
- Package pattern_mon_pkg holds:
  - HIT_W=3
  - typedef struct packed {logic [7:0] data; logic [2:0] hit;} pm_evt_t
  - typedef enum {IDLE, RUN, ALARM} pm_state_t
- Sub-module pattern_evt_fifo is a parameterised synchronous FIFO of pm_evt_t with push, pop, full, empty and flush.
- The top level contains the counters, the run FSM, the overflow flag and the FIFO instance.

## Test plan
- Reset then idle: after rst_n deasserts, every output is 0 and evt_valid=0 for 10 cycles with in_valid=0.
- Count and queue: samples B4/hit=001, C3/hit=010, 4A/hit=100, 97/hit=000, with evt_ready=1 throughout.
  - Required: cnt1=1, cnt2=1, cnt3=1.
  - Exactly three events pop in order B4, C3, 4A; 97 is never queued.
- Overflow: evt_ready=0, then 5 hit samples 01..05 with DEPTH=4.
  - Required: overflow=1 one cycle after the 5th sample; the FIFO holds 01..04.
  - Set evt_ready=1: 01..04 drain on 4 consecutive cycles, then evt_valid=0.
- Full push+pop: with the FIFO full, present a hit sample while evt_ready=1.
  - Required: overflow stays 0 and the new entry is last in drain order.
- Run alarm: hit, gap (in_valid=0), hit, hit gives run_alarm=1 one cycle after the third hit. A no-hit valid sample drops run_alarm the next cycle.
- Saturation and clear: with CNT_W=4, 17 samples with hit=001 leave cnt1=15. Pulsing clear in the same cycle as a hit sample gives cnt1=0, evt_valid=0, overflow=0, and the sample is not counted.

Source files
------------

// File: rtl/pattern_mon_pkg.sv
// Shared types for the pattern event monitor slice.
//   HIT_W      : number of pattern match flags from the upstream detector
//   pm_evt_t   : one queued event, the detector word plus its match flags
//   pm_state_t : states of the consecutive-match run tracker
package pattern_mon_pkg;

  localparam int HIT_W  = 3;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [HIT_W-1:0]  hit;
  } pm_evt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } pm_state_t;

endpackage

// File: rtl/pattern_evt_fifo.sv
// Synchronous FIFO of pm_evt_t entries with a synchronous flush.
// The head entry is read straight from the storage registers, so it
// appears on head one cycle after it is pushed into an empty FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO; overrides push and pop this cycle
//   push       : write push_evt (accepted when not full, or full with a pop)
//   push_evt   : entry to write
//   pop        : remove head entry (ignored when empty)
//   head       : current head entry
//   full/empty : occupancy flags
module pattern_evt_fifo
  import pattern_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  logic    push,
  input  pm_evt_t push_evt,
  input  logic    pop,
  output pm_evt_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty differ.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  pm_evt_t     mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot being written, so a full FIFO still accepts a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_evt;
    end
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pattern_event_monitor.sv
// Monitor stage behind the wildcard pattern detector. Counts hits per
// pattern with saturation, queues matching words for a downstream
// consumer, and raises an alarm after RUN_THRESH consecutive matching
// valid samples.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/data/hit    : detector sample; hit = {p3, p2, p1}
//   clear                : synchronous flush of all state; beats any sample
//   evt_valid/ready      : head-of-queue handshake
//   evt_data/evt_hit     : head entry
//   cnt1..cnt3           : saturating per-pattern hit counts
//   run_alarm            : high while the run tracker is in ALARM
//   overflow             : sticky; an event was dropped on a full queue
module pattern_event_monitor
  import pattern_mon_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16,
  parameter int RUN_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic [2:0]       in_hit,
  input  logic             clear,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_data,
  output logic [2:0]       evt_hit,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic             run_alarm,
  output logic             overflow
);

  localparam int RL_W = (RUN_THRESH < 2) ? 1 : $clog2(RUN_THRESH + 1);
  localparam logic [RL_W-1:0] THRESH_M1 = RL_W'(RUN_THRESH - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic      accepted;
  logic      is_hit;
  logic      push_req;
  logic      pop_req;
  logic      fifo_full;
  logic      fifo_empty;
  pm_evt_t   push_evt;
  pm_evt_t   head;
  pm_state_t state, state_n;
  logic [RL_W-1:0] run_len, run_len_n;

  assign accepted = in_valid && !clear;
  assign is_hit   = |in_hit;
  assign push_req = accepted && is_hit;
  assign pop_req  = evt_valid && evt_ready && !clear;

  assign push_evt.data = in_data;
  assign push_evt.hit  = in_hit;

  pattern_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (clear),
    .push     (push_req),
    .push_evt (push_evt),
    .pop      (pop_req),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_data  = head.data;
  assign evt_hit   = head.hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
      cnt2 <= '0;
      cnt3 <= '0;
    end else if (clear) begin
      cnt1 <= '0;
      cnt2 <= '0;
      cnt3 <= '0;
    end else if (accepted) begin
      if (in_hit[0]) cnt1 <= sat_inc(cnt1);
      if (in_hit[1]) cnt2 <= sat_inc(cnt2);
      if (in_hit[2]) cnt3 <= sat_inc(cnt3);
    end
  end

  // A drop only happens when the queue is full and nothing leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop_req) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      run_len <= '0;
    end else begin
      state   <= state_n;
      run_len <= run_len_n;
    end
  end

  // Run tracker only moves on accepted samples; run_len freezes in ALARM.
  always_comb begin
    state_n   = state;
    run_len_n = run_len;
    if (clear) begin
      state_n   = IDLE;
      run_len_n = '0;
    end else if (in_valid) begin
      case (state)
        IDLE: begin
          if (is_hit) begin
            run_len_n = RL_W'(1);
            state_n   = (RUN_THRESH == 1) ? ALARM : RUN;
          end
        end
        RUN: begin
          if (is_hit) begin
            run_len_n = run_len + 1'b1;
            if (run_len == THRESH_M1) state_n = ALARM;
          end else begin
            state_n   = IDLE;
            run_len_n = '0;
          end
        end
        ALARM: begin
          if (!is_hit) begin
            state_n   = IDLE;
            run_len_n = '0;
          end
        end
        default: begin
          state_n   = IDLE;
          run_len_n = '0;
        end
      endcase
    end
  end

  assign run_alarm = (state == ALARM);

endmodule

// File: tb/tb_pattern_event_monitor.sv
module tb_pattern_event_monitor;

  localparam int DEPTH      = 4;
  localparam int CNT_W      = 4;
  localparam int RUN_THRESH = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [7:0]       in_data;
  logic [2:0]       in_hit;
  logic             clear;
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_data;
  logic [2:0]       evt_hit;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt3;
  logic             run_alarm;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  logic [10:0] got_q[$];

  pattern_event_monitor #(
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W),
    .RUN_THRESH (RUN_THRESH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_hit    (in_hit),
    .clear     (clear),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_hit   (evt_hit),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .run_alarm (run_alarm),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every handshake that completes at a rising edge.
  always @(posedge clk) begin
    if (rst_n && evt_valid && evt_ready && !clear) got_q.push_back({evt_data, evt_hit});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] d, input logic [2:0] h);
    in_valid = 1'b1;
    in_data  = d;
    in_hit   = h;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_hit    = 3'b000;
    clear     = 1'b0;
    evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      chk("idle_valid", evt_valid, 0);
      chk("idle_outs", {evt_data, evt_hit, cnt1, cnt2, cnt3, run_alarm, overflow}, 0);
      step();
    end

    // Count and queue, three hits in a row also trips the run alarm
    evt_ready = 1'b1;
    got_q.delete();
    sample(8'hB4, 3'b001);
    sample(8'hC3, 3'b010);
    chk("run_before3", run_alarm, 0);
    sample(8'h4A, 3'b100);
    chk("run_at3", run_alarm, 1);
    sample(8'h97, 3'b000);
    chk("run_drop", run_alarm, 0);
    repeat (3) step();
    chk("cq_cnt1", cnt1, 1);
    chk("cq_cnt2", cnt2, 1);
    chk("cq_cnt3", cnt3, 1);
    chk("cq_npop", got_q.size(), 3);
    chk("cq_pop0", got_q[0], {8'hB4, 3'b001});
    chk("cq_pop1", got_q[1], {8'hC3, 3'b010});
    chk("cq_pop2", got_q[2], {8'h4A, 3'b100});
    chk("cq_empty", evt_valid, 0);

    // Overflow
    pulse_clear();
    chk("clr_cnt2", cnt2, 0);
    evt_ready = 1'b0;
    for (int i = 1; i <= 4; i++) sample(8'(i), 3'b001);
    chk("ovf_before", overflow, 0);
    sample(8'h05, 3'b001);
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt1", cnt1, 5);
    evt_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain_v", evt_valid, 1);
      chk("ovf_drain_d", evt_data, i);
      step();
    end
    chk("ovf_drained", evt_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Full push+pop
    pulse_clear();
    chk("clr_ovf", overflow, 0);
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(8'h11 + 8'(i), 3'b010);
    got_q.delete();
    evt_ready = 1'b1;
    sample(8'h15, 3'b010);
    chk("fpp_ovf", overflow, 0);
    repeat (6) step();
    chk("fpp_npop", got_q.size(), 5);
    chk("fpp_first", got_q[0], {8'h11, 3'b010});
    chk("fpp_last", got_q[4], {8'h15, 3'b010});
    chk("fpp_ovf2", overflow, 0);

    // Run alarm across an in_valid gap
    pulse_clear();
    sample(8'h21, 3'b001);
    in_hit = 3'b001;
    step();
    chk("gap_alarm", run_alarm, 0);
    sample(8'h22, 3'b001);
    chk("gap_before3", run_alarm, 0);
    sample(8'h23, 3'b001);
    chk("gap_alarm3", run_alarm, 1);
    sample(8'h24, 3'b100);
    chk("gap_stay", run_alarm, 1);
    sample(8'h25, 3'b000);
    chk("gap_drop", run_alarm, 0);

    // Saturation and clear
    pulse_clear();
    evt_ready = 1'b0;
    for (int i = 0; i < 15; i++) sample(8'h30 + 8'(i), 3'b001);
    chk("sat_15", cnt1, 15);
    sample(8'h40, 3'b001);
    sample(8'h41, 3'b001);
    chk("sat_17", cnt1, 15);
    chk("sat_ovf", overflow, 1);
    chk("sat_alarm", run_alarm, 1);
    in_valid = 1'b1;
    in_data  = 8'h50;
    in_hit   = 3'b001;
    clear    = 1'b1;
    step();
    in_valid = 1'b0;
    clear    = 1'b0;
    chk("clr_cnt1", cnt1, 0);
    chk("clr_valid", evt_valid, 0);
    chk("clr_ovf2", overflow, 0);
    chk("clr_alarm", run_alarm, 0);
    step();
    chk("clr_hold", cnt1, 0);

    // Asynchronous reset mid-operation
    sample(8'h61, 3'b011);
    sample(8'h62, 3'b001);
    chk("ar_valid_pre", evt_valid, 1);
    chk("ar_cnt2_pre", cnt2, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", evt_valid, 0);
    chk("ar_cnts", {cnt1, cnt2, cnt3}, 0);
    chk("ar_data", evt_data, 0);
    rst_n = 1'b1;
    step();
    chk("ar_after", evt_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
